// File: rtl/decode_stage.sv
// Registered instruction decode stage with a two-entry skid buffer and HALT tracking.
// Optional delivered-instruction counter enabled by DECODE_PERF_CNT_EN.
module decode_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_ins,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [5:0]      opcode,
   output logic [5:0]      funct,
   output logic [4:0]      rs,
   output logic [4:0]      rt,
   output logic [4:0]      rd,
   output logic [4:0]      shamt,
   output logic [XLEN-1:0] imm,
   output logic            is_rtype,
   output logic            is_halt,
   output logic            halted
`ifdef DECODE_PERF_CNT_EN
   ,output logic [CNT_W-1:0] dec_count
`endif
);

   if (XLEN < 16 || XLEN > 64 || CNT_W < 1) begin : g_param_check
      $error("decode_stage: XLEN must be 16..64 and CNT_W at least 1");
   end

   typedef struct packed {
      logic [5:0]      opcode;
      logic [5:0]      funct;
      logic [4:0]      rs;
      logic [4:0]      rt;
      logic [4:0]      rd;
      logic [4:0]      shamt;
      logic [XLEN-1:0] imm;
      logic            is_rtype;
      logic            is_halt;
   } dec_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_HALT  = 6'b010110;
   localparam logic [5:0] OP_NOP   = 6'b010111;
   localparam logic [5:0] OP_RET   = 6'b011000;
   localparam logic [5:0] OP_MOVE  = 6'b010010;

   dec_t dec_d;
   dec_t or_q, or_d;
   dec_t sr_q, sr_d;
   logic or_valid_q, or_valid_d;
   logic sr_valid_q, sr_valid_d;
   logic halted_q, halted_d;
   logic accept;
   logic consume;

   always_comb begin
      dec_d        = '0;
      dec_d.opcode = in_ins[31:26];
      unique case (in_ins[31:26])
         OP_RTYPE: begin
            dec_d.rs       = in_ins[25:21];
            dec_d.rt       = in_ins[20:16];
            dec_d.rd       = in_ins[15:11];
            dec_d.shamt    = in_ins[10:6];
            dec_d.funct    = in_ins[5:0];
            dec_d.is_rtype = 1'b1;
         end
         OP_HALT:        dec_d.is_halt = 1'b1;
         OP_NOP, OP_RET: ;
         OP_MOVE: begin
            dec_d.rs = in_ins[25:21];
            dec_d.rt = in_ins[20:16];
         end
         default: begin
            dec_d.rs  = in_ins[25:21];
            dec_d.rt  = in_ins[20:16];
            dec_d.imm = XLEN'($signed(in_ins[15:0]));
         end
      endcase
   end

   assign in_ready = !sr_valid_q && !halted_q && !flush;
   assign accept   = in_valid && in_ready;
   assign consume  = or_valid_q && out_ready;

   // Accept while SR is full cannot happen, so a consume either drains SR or refills from input.
   always_comb begin
      or_d       = or_q;
      sr_d       = sr_q;
      or_valid_d = or_valid_q;
      sr_valid_d = sr_valid_q;
      halted_d   = halted_q;
      if (flush) begin
         or_valid_d = 1'b0;
         sr_valid_d = 1'b0;
         halted_d   = 1'b0;
      end else begin
         if (consume) begin
            if (sr_valid_q) begin
               or_d       = sr_q;
               sr_valid_d = 1'b0;
            end else if (accept) begin
               or_d = dec_d;
            end else begin
               or_valid_d = 1'b0;
            end
         end else if (!or_valid_q) begin
            if (accept) begin
               or_d       = dec_d;
               or_valid_d = 1'b1;
            end
         end else if (accept) begin
            sr_d       = dec_d;
            sr_valid_d = 1'b1;
         end
         if (accept && dec_d.is_halt) halted_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         or_q       <= '0;
         sr_q       <= '0;
         or_valid_q <= 1'b0;
         sr_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         or_q       <= or_d;
         sr_q       <= sr_d;
         or_valid_q <= or_valid_d;
         sr_valid_q <= sr_valid_d;
         halted_q   <= halted_d;
      end
   end

   assign out_valid = or_valid_q;
   assign opcode    = or_q.opcode;
   assign funct     = or_q.funct;
   assign rs        = or_q.rs;
   assign rt        = or_q.rt;
   assign rd        = or_q.rd;
   assign shamt     = or_q.shamt;
   assign imm       = or_q.imm;
   assign is_rtype  = or_q.is_rtype;
   assign is_halt   = or_q.is_halt;
   assign halted    = halted_q;

`ifdef DECODE_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Counts every downstream handshake, including one coinciding with a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt_q <= '0;
      else if (consume) cnt_q <= cnt_q + CNT_W'(1);
   end

   assign dec_count = cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage against a FIFO-level reference model.
module tb_decode_stage;
   localparam int unsigned CW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] in_ins = '0;

   logic        in_ready, out_valid, is_rtype, is_halt, halted;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] imm32;
   logic [CW-1:0] dec_count;

   logic        in_ready64, out_valid64, is_rtype64, is_halt64, halted64;
   logic [5:0]  opcode64, funct64;
   logic [4:0]  rs64, rt64, rd64, shamt64;
   logic [63:0] imm64;
   logic [15:0] dec_count64;

   decode_stage #(.XLEN(32), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
      .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm32),
      .is_rtype(is_rtype), .is_halt(is_halt), .halted(halted)
`ifdef DECODE_PERF_CNT_EN
      , .dec_count(dec_count)
`endif
   );

   decode_stage #(.XLEN(64), .CNT_W(16)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64), .in_ins(in_ins),
      .flush(flush), .out_valid(out_valid64), .out_ready(out_ready), .opcode(opcode64),
      .funct(funct64), .rs(rs64), .rt(rt64), .rd(rd64), .shamt(shamt64), .imm(imm64),
      .is_rtype(is_rtype64), .is_halt(is_halt64), .halted(halted64)
`ifdef DECODE_PERF_CNT_EN
      , .dec_count(dec_count64)
`endif
   );

`ifndef DECODE_PERF_CNT_EN
   assign dec_count   = '0;
   assign dec_count64 = '0;
`endif

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [63:0] imm;
      logic        is_rtype;
      logic        is_halt;
   } exp_t;

   exp_t        mq[$];
   bit          mhalt;
   int unsigned mcnt;
   int          tests_run;
   int          tests_failed;
   exp_t        g32, g64;

   always_comb begin
      g32 = '{opcode: opcode, funct: funct, rs: rs, rt: rt, rd: rd, shamt: shamt,
              imm: {32'b0, imm32}, is_rtype: is_rtype, is_halt: is_halt};
      g64 = '{opcode: opcode64, funct: funct64, rs: rs64, rt: rt64, rd: rd64, shamt: shamt64,
              imm: imm64, is_rtype: is_rtype64, is_halt: is_halt64};
   end

   function automatic exp_t ref_dec(input logic [31:0] w);
      exp_t e;
      logic [5:0] op;
      op = w[31:26];
      e = '0;
      e.opcode = op;
      if (op == 6'd0) begin
         e.rs = w[25:21]; e.rt = w[20:16]; e.rd = w[15:11];
         e.shamt = w[10:6]; e.funct = w[5:0]; e.is_rtype = 1'b1;
      end else if (op == 6'h16 || op == 6'h17 || op == 6'h18) begin
         e.is_halt = (op == 6'h16);
      end else if (op == 6'h12) begin
         e.rs = w[25:21]; e.rt = w[20:16];
      end else begin
         e.rs = w[25:21]; e.rt = w[20:16];
         e.imm = w[15] ? 64'(w[15:0]) - 64'd65536 : 64'(w[15:0]);
      end
      return e;
   endfunction

   function automatic exp_t mask32(input exp_t e);
      exp_t m;
      m = e;
      m.imm[63:32] = '0;
      return m;
   endfunction

   function automatic bit model_ready();
      return (mq.size() < 2) && !mhalt && !flush;
   endfunction

   function automatic logic [31:0] rand_ins(input bit allow_halt);
      logic [31:0] w;
      int unsigned k;
      w = $urandom;
      k = $urandom_range(0, 9);
      case (k)
         0, 1: w[31:26] = 6'h00;
         2:    w[31:26] = (allow_halt && $urandom_range(0, 2) == 0) ? 6'h16 : 6'h17;
         3:    w[31:26] = 6'h18;
         4:    w[31:26] = 6'h12;
         default: ;
      endcase
      if (!allow_halt && w[31:26] == 6'h16) w[31:26] = 6'h17;
      return w;
   endfunction

   // Called just after a falling edge; advances one clock and updates the reference model.
   task automatic tick();
      bit acc, cons;
      exp_t dropped;
      acc  = in_valid && model_ready();
      cons = (mq.size() > 0) && out_ready;
      @(posedge clk);
      if (cons) mcnt++;
      if (flush) begin
         mq.delete();
         mhalt = 1'b0;
      end else begin
         if (cons) dropped = mq.pop_front();
         if (acc) begin
            mq.push_back(ref_dec(in_ins));
            if (in_ins[31:26] == 6'h16) mhalt = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      mq.delete(); mhalt = 1'b0; mcnt = 0;
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || halted !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: out_valid=%b halted=%b, expected 0 0", out_valid, halted);
      end
      tests_run++;
      if (g32 !== '0 || g64 !== '0) begin
         tests_failed++;
         $display("FAIL reset_fields: got32=%h got64=%h, expected all zero", g32, g64);
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
`ifdef DECODE_PERF_CNT_EN
      tests_run++;
      if (dec_count !== '0) begin
         tests_failed++;
         $display("FAIL reset_dec_count: got %0d expected 0", dec_count);
      end
`endif
   endtask

   task automatic test_rtype();
      exp_t e;
      e = '0;
      e.rs = 5'd9; e.rt = 5'd10; e.rd = 5'd8; e.funct = 6'h20; e.is_rtype = 1'b1;
      out_ready = 1'b1; in_valid = 1'b1; in_ins = 32'h012A4020;
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || g32 !== e || g64 !== e) begin
         tests_failed++;
         $display("FAIL rtype_decode: valid=%b got32=%h got64=%h, expected valid=1 fields=%h",
                  out_valid, g32, g64, e);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL rtype_drain: out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_imm();
      out_ready = 1'b1; in_valid = 1'b1;
      in_ins = {6'b001000, 5'd3, 5'd4, 16'h8000};
      tick();
      in_ins = {6'b010010, 5'd3, 5'd4, 16'h8000};
      tests_run++;
      if (out_valid !== 1'b1 || imm32 !== 32'hFFFF8000 || imm64 !== 64'hFFFF_FFFF_FFFF_8000
          || rs !== 5'd3 || rt !== 5'd4) begin
         tests_failed++;
         $display("FAIL itype_sign_ext: valid=%b imm32=%h imm64=%h rs=%0d rt=%0d, expected FFFF8000 FFFFFFFFFFFF8000 3 4",
                  out_valid, imm32, imm64, rs, rt);
      end
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || imm32 !== '0 || imm64 !== '0 || opcode !== 6'b010010
          || rs !== 5'd3 || rt !== 5'd4) begin
         tests_failed++;
         $display("FAIL move_imm_zero: valid=%b op=%h imm32=%h imm64=%h rs=%0d rt=%0d, expected op=12 imm=0 rs=3 rt=4",
                  out_valid, opcode, imm32, imm64, rs, rt);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [31:0] sent[$];
      logic [31:0] pend[$];
      exp_t        got[$];
      int          cyc;
      for (int i = 0; i < 4; i++) sent.push_back(rand_ins(1'b0));
      pend = sent;
      cyc = 0;
      while ((pend.size() > 0 || mq.size() > 0) && cyc < 30) begin
         in_valid  = (pend.size() > 0);
         in_ins    = (pend.size() > 0) ? pend[0] : 32'h0;
         out_ready = !(cyc >= 1 && cyc <= 3);
         #1;
         tests_run++;
         if (in_ready !== model_ready()) begin
            tests_failed++;
            $display("FAIL bp_in_ready cyc%0d: got %b expected %b", cyc, in_ready, model_ready());
         end
         if (cyc == 2) begin
            tests_run++;
            if (in_ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL bp_skid_full: in_ready=%b after two accepts, expected 0", in_ready);
            end
         end
         if (out_valid === 1'b1 && out_ready) got.push_back(g32);
         if (in_valid && model_ready()) void'(pend.pop_front());
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      tests_run++;
      if (got.size() != 4) begin
         tests_failed++;
         $display("FAIL bp_count: delivered %0d expected 4", got.size());
      end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         tests_run++;
         if (got[i] !== mask32(ref_dec(sent[i]))) begin
            tests_failed++;
            $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i], mask32(ref_dec(sent[i])));
         end
      end
   endtask

   task automatic test_halt();
      logic [31:0] x, addi;
      x    = {6'b001101, 5'd7, 5'd8, 16'h1234};
      addi = {6'b001000, 5'd1, 5'd2, 16'hFFFE};
      // HALT behind an instruction already in the output register
      out_ready = 1'b0; in_valid = 1'b1; in_ins = x;
      tick();
      in_ins = 32'h5800_0000;
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (halted !== 1'b1 || in_ready !== 1'b0 || g32 !== mask32(ref_dec(x))) begin
         tests_failed++;
         $display("FAIL halt_queued: halted=%b in_ready=%b head=%h, expected 1 0 %h",
                  halted, in_ready, g32, mask32(ref_dec(x)));
      end
      out_ready = 1'b1;
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || is_halt !== 1'b1 || g32 !== mask32(ref_dec(32'h5800_0000))) begin
         tests_failed++;
         $display("FAIL halt_second: valid=%b is_halt=%b head=%h, expected halt bundle", out_valid, is_halt, g32);
      end
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      // HALT then an ADDI held off until flush
      in_valid = 1'b1; in_ins = 32'h5800_0000;
      tick();
      in_ins = addi;
      tests_run++;
      if (out_valid !== 1'b1 || is_halt !== 1'b1 || halted !== 1'b1 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL halt_state: valid=%b is_halt=%b halted=%b in_ready=%b, expected 1 1 1 0",
                  out_valid, is_halt, halted, in_ready);
      end
      repeat (3) tick();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL halt_blocks: out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      tests_run++;
      if (halted !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL halt_flush_release: halted=%b in_ready=%b, expected 0 1", halted, in_ready);
      end
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || g32 !== mask32(ref_dec(addi)) || g64 !== ref_dec(addi)) begin
         tests_failed++;
         $display("FAIL halt_addi_after: valid=%b got=%h expected %h", out_valid, g64, ref_dec(addi));
      end
      tick();
   endtask

   task automatic test_flush_full();
      out_ready = 1'b0; in_valid = 1'b1;
      in_ins = rand_ins(1'b0);
      tick();
      in_ins = rand_ins(1'b0);
      tick();
      in_ins = rand_ins(1'b0);
      flush = 1'b1; out_ready = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_pre: in_ready=%b out_valid=%b, expected 0 1", in_ready, out_valid);
      end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_clears: out_valid=%b expected 0", out_valid);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_no_accept: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
`ifdef DECODE_PERF_CNT_EN
      tests_run++;
      if (dec_count !== CW'(mcnt)) begin
         tests_failed++;
         $display("FAIL flush_dec_count: got %0d expected %0d", dec_count, CW'(mcnt));
      end
`endif
   endtask

`ifdef DECODE_PERF_CNT_EN
   task automatic test_counter();
      int guard;
      test_reset();
      out_ready = 1'b1; in_valid = 1'b1;
      guard = 0;
      while (mcnt < 17 && guard < 40) begin
         in_ins = rand_ins(1'b0);
         tick();
         guard++;
      end
      in_valid = 1'b0;
      tests_run++;
      if (mcnt != 17 || dec_count !== 4'd1) begin
         tests_failed++;
         $display("FAIL count_wrap: dec_count=%0d after %0d deliveries, expected 1 after 17", dec_count, mcnt);
      end
      in_valid = 1'b1;
      repeat (3) begin
         in_ins = rand_ins(1'b0);
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || dec_count !== '0 || halted !== 1'b0) begin
         tests_failed++;
         $display("FAIL count_async_reset: out_valid=%b dec_count=%0d halted=%b, expected 0 0 0",
                  out_valid, dec_count, halted);
      end
      in_valid = 1'b0;
      @(negedge clk);
      mq.delete(); mhalt = 1'b0; mcnt = 0;
      rst_n = 1'b1;
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_ins    = rand_ins(1'b1);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 99) < 4);
         #1;
         tests_run++;
         if (in_ready !== model_ready()) begin
            tests_failed++;
            $display("FAIL rnd_in_ready c%0d: got %b expected %b", c, in_ready, model_ready());
         end
         tick();
         tests_run++;
         if (out_valid !== (mq.size() > 0) || halted !== mhalt) begin
            tests_failed++;
            $display("FAIL rnd_state c%0d: out_valid=%b halted=%b, expected %b %b",
                     c, out_valid, halted, mq.size() > 0, mhalt);
         end else if (mq.size() > 0) begin
            tests_run++;
            if (g32 !== mask32(mq[0]) || g64 !== mq[0]) begin
               tests_failed++;
               $display("FAIL rnd_fields c%0d: got64=%h expected %h", c, g64, mq[0]);
            end
         end
`ifdef DECODE_PERF_CNT_EN
         tests_run++;
         if (dec_count !== CW'(mcnt)) begin
            tests_failed++;
            $display("FAIL rnd_dec_count c%0d: got %0d expected %0d", c, dec_count, CW'(mcnt));
         end
`endif
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_rtype();
      test_imm();
      test_backpressure();
      test_halt();
      test_flush_full();
`ifdef DECODE_PERF_CNT_EN
      test_counter();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
